hello_uart_tx: RTL

//   Design under test for the hello-world bench. On a start pulse, serialises the fixed message
//   "Hello World!\r\n" (14 bytes) on a UART 8N1 line, LSB first.

---
 rtl/tc_uart_pkg.sv | 21 ++
 rtl/uart_tx_byte.sv | 86 ++++++++
 rtl/hello_uart_tx.sv | 80 ++++++++
 3 files changed

// File: rtl/tc_uart_pkg.sv
// Shared types and message ROM for the hello-world UART transmitter.
// Parity build option: UART_PARITY_EN.
package tc_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int HELLO_MSG_LEN = 14;

  // Entry 0 is the first byte sent: "Hello World!\r\n"
  localparam logic [HELLO_MSG_LEN-1:0][7:0] HELLO_MSG = {
    8'h0A, 8'h0D, 8'h21, 8'h64, 8'h6C, 8'h72, 8'h6F,
    8'h57, 8'h20, 8'h6F, 8'h6C, 8'h6C, 8'h65, 8'h48
  };

endpackage

// File: rtl/uart_tx_byte.sv
// One 8N1 byte frame serialiser with baud and bit counters.
// UART_PARITY_EN adds an even parity bit between DATA and STOP.
module uart_tx_byte
  import tc_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_e r_state;
  uart_state_e w_state_n;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_data;
  logic          w_tick;
  logic          w_cnt_clr;

  assign w_tick = (r_cnt == C_LAST);
  assign w_cnt_clr = w_tick
                   | (w_state_n != r_state)
                   | (r_state == IDLE);

  always_comb begin
    w_state_n = r_state;
    ready     = 1'b0;
    tx        = 1'b1;
    unique case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (load) w_state_n = START;
      end
      START: begin
        tx = 1'b0;
        if (w_tick) w_state_n = DATA;
      end
      DATA: begin
        tx = r_data[r_bit];
        if (w_tick && r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
          w_state_n = PARITY;
`else
          w_state_n = STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        tx = ^r_data;
        if (w_tick) w_state_n = STOP;
      end
`endif
      STOP: begin
        // Reloading on the final stop cycle keeps frames gapless
        ready = w_tick;
        if (w_tick) w_state_n = load ? START : IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_data  <= 8'h00;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      if (r_state == DATA && w_tick)
        r_bit <= r_bit + 3'd1;
      if (ready && load)
        r_data <= data;
    end
  end

endmodule

// File: rtl/hello_uart_tx.sv
// Message sequencer: streams the hello ROM through uart_tx_byte.
// Parity build option: UART_PARITY_EN.
module hello_uart_tx
  import tc_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       tx,
  output logic       byte_vld,
  output logic [7:0] byte_data
);

  localparam int IW = $clog2(HELLO_MSG_LEN);
  localparam logic [IW-1:0] I_LAST = IW'(HELLO_MSG_LEN - 1);

  logic [IW-1:0] r_idx;
  logic          r_busy;
  logic          r_done;
  logic          r_vld;
  logic [7:0]    r_data;

  logic          w_ready;
  logic          w_fin;
  logic          w_last;
  logic          w_accept;
  logic          w_load;
  logic [IW-1:0] w_idx_n;
  logic [7:0]    w_byte;

  assign w_fin    = r_busy & w_ready;
  assign w_last   = (r_idx == I_LAST);
  // A start landing on the final stop cycle chains a new message
  assign w_accept = start & (~r_busy | (w_fin & w_last));
  assign w_load   = w_accept | (w_fin & ~w_last);
  assign w_idx_n  = w_accept ? '0 : r_idx + 1'b1;
  assign w_byte   = HELLO_MSG[w_idx_n];

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .data (w_byte),
    .ready(w_ready),
    .tx   (tx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_vld  <= 1'b0;
      r_data <= 8'h00;
    end else begin
      r_vld  <= w_load;
      r_done <= w_fin & w_last;
      if (w_load) begin
        r_idx  <= w_idx_n;
        r_data <= w_byte;
        r_busy <= 1'b1;
      end else if (w_fin && w_last) begin
        r_idx  <= '0;
        r_busy <= 1'b0;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign byte_vld  = r_vld;
  assign byte_data = r_data;

endmodule
